// File: rtl/alu_op_sequencer_if.sv
// Request/ALU/response bundle for alu_op_sequencer.
// The slave modport is the sequencer; the master modport is the requester/ALU side.
interface alu_op_sequencer_if #(
  parameter int unsigned WIDTH = 24
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] AluA;
  logic [WIDTH-1:0] AluB;
  logic [2:0]       Selector;
  logic [WIDTH-1:0] alu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] Result;
  logic             Err;
  logic             Busy;

  modport master (
    output req_valid, Op, A, B, alu_result, rsp_ready,
    input  req_ready, AluA, AluB, Selector, rsp_valid, Result, Err, Busy
  );

  modport slave (
    input  req_valid, Op, A, B, alu_result, rsp_ready,
    output req_ready, AluA, AluB, Selector, rsp_valid, Result, Err, Busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Valid/ready front end for the ALU and result mux; one operation in flight at a time.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add MUL path; otherwise Op 100 is rejected.
module alu_op_sequencer #(
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned MUL_STEPS = WIDTH
) (
  input logic               Clock,
  input logic               Reset,
  alu_op_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_LESS = 3'b011,
    OP_MUL  = 3'b100,
    OP_XOR  = 3'b101
  } op_e;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_RESP = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd3
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       sel_q, sel_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic             rsp_valid_q, rsp_valid_d;

`ifdef ALU_SEQ_MUL_EN
  localparam int unsigned CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_sum;
  logic             mul_last;

  // Accumulator value after the current step; the final step forwards it straight to Result.
  assign acc_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mul_last = (cnt_q == CNT_W'(MUL_STEPS - 1));
`endif

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    sel_d       = sel_q;
    result_d    = result_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
`ifdef ALU_SEQ_MUL_EN
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          alu_a_d = bus.A;
          alu_b_d = bus.B;
          sel_d   = bus.Op;
          case (bus.Op)
            OP_AND, OP_OR, OP_ADD, OP_LESS, OP_XOR: begin
              state_d = S_EXEC;
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
              state_d  = S_MUL;
              acc_d    = '0;
              mcand_d  = bus.A;
              mplier_d = bus.B;
              cnt_d    = '0;
            end
`endif
            default: begin
              state_d     = S_RESP;
              result_d    = '0;
              err_d       = 1'b1;
              rsp_valid_d = 1'b1;
            end
          endcase
        end
      end

      S_EXEC: begin
        result_d    = bus.alu_result;
        err_d       = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end

`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (mul_last) begin
          result_d    = acc_sum;
          err_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
`endif

      S_RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      sel_q       <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      sel_q       <= sel_d;
      result_q    <= result_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef ALU_SEQ_MUL_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

  assign bus.req_ready = (state_q == S_IDLE) && !Reset;
  assign bus.Busy      = (state_q != S_IDLE);
  assign bus.AluA      = alu_a_q;
  assign bus.AluB      = alu_b_q;
  assign bus.Selector  = sel_q;
  assign bus.Result    = result_q;
  assign bus.Err       = err_q;
  assign bus.rsp_valid = rsp_valid_q;

endmodule
